// File: rtl/cipher_stream_ctrl.sv
// cipher_stream_ctrl: Wishbone/byte-stream front end for an external block-cipher core
// Loads a block through Wishbone writes or an s_valid/s_ready byte stream.
// Starts the core and waits for core_done, with a timeout.
// Returns the result through Wishbone reads or an m_valid/m_ready byte stream.
// Ports:
//   clk, reset_n                  : clock and asynchronous active-low reset
//   i_wb_* / o_wb_*               : Wishbone slave (32-bit, byte addressed, BASE_ADDRESS)
//   s_valid/s_data/s_ready        : input byte stream
//   m_valid/m_data/m_ready        : output byte stream
//   core_text/key/start/encrypt   : to the cipher core
//   core_result/core_done         : from the cipher core
//   irq                           : interrupt output
// Optional: define CIPHER_STREAM_IRQ_EN to enable irq = IE & (DONE | TIMEOUT).
// Without it, irq is tied 0 and CTRL[3] reads 0.
module cipher_stream_ctrl #(
  parameter logic [31:0] BASE_ADDRESS   = 32'h3000_0000,
  parameter int          BLOCK_BYTES    = 8,
  parameter int          TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_wb_cyc,
  input  logic                     i_wb_stb,
  input  logic                     i_wb_we,
  input  logic [31:0]              i_wb_addr,
  input  logic [31:0]              i_wb_data,
  output logic                     o_wb_ack,
  output logic                     o_wb_stall,
  output logic [31:0]              o_wb_data,
  input  logic                     s_valid,
  input  logic [7:0]               s_data,
  output logic                     s_ready,
  output logic                     m_valid,
  output logic [7:0]               m_data,
  input  logic                     m_ready,
  output logic [8*BLOCK_BYTES-1:0] core_text,
  output logic [8*BLOCK_BYTES-1:0] core_key,
  output logic                     core_start,
  output logic                     core_encrypt,
  input  logic [8*BLOCK_BYTES-1:0] core_result,
  input  logic                     core_done,
  output logic                     irq
);
  localparam int W = BLOCK_BYTES / 4;
  localparam int N = 8 * BLOCK_BYTES;
  localparam int KW = (W > 1) ? $clog2(W) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [7:0] LAST = 8'(BLOCK_BYTES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, UNLOAD} state_t;

  state_t state, nstate;
  logic [N-1:0] in_reg, out_reg, key_reg;
  logic encrypt, stream_en, done, tmo, werr, from_stream, ie_rd;
  logic [7:0] idx;
  logic [TW-1:0] tcnt;
  logic [31:0] off, rdata;
  logic [29:0] wi;
  logic [KW-1:0] k;
  logic sel_in, sel_out, sel_key, sel_ctrl, sel_sts, req, wr, busy, go, tlast, wr_ok;

  assign off      = i_wb_addr - BASE_ADDRESS;
  assign wi       = off[31:2];
  assign sel_in   = wi < 30'(W);
  assign sel_out  = !sel_in && wi < 30'(2 * W);
  assign sel_key  = wi >= 30'(2 * W) && wi < 30'(3 * W);
  assign sel_ctrl = wi == 30'(3 * W);
  assign sel_sts  = wi == 30'(3 * W + 1);
  assign req      = i_wb_cyc && i_wb_stb && off[1:0] == 2'b00 && wi < 30'(3 * W + 2);
  assign wr       = req && i_wb_we;
  assign busy     = state != IDLE;
  // IN, KEY and CTRL writes are only honoured while idle
  assign wr_ok    = wr && !busy;
  assign go       = wr_ok && sel_ctrl && i_wb_data[0];
  assign tlast    = tcnt == TW'(TIMEOUT_CYCLES - 1);
  assign k        = KW'(sel_in ? wi : sel_out ? wi - 30'(W) : wi - 30'(2 * W));

  assign o_wb_stall   = 1'b0;
  assign core_text    = in_reg;
  assign core_key     = key_reg;
  assign core_encrypt = encrypt;

  always_comb begin
    rdata = sel_in   ? in_reg[32*k +: 32] :
            sel_out  ? out_reg[32*k +: 32] :
            sel_key  ? key_reg[32*k +: 32] :
            sel_ctrl ? {28'd0, ie_rd, stream_en, encrypt, 1'b0} :
                       {16'd0, idx, 4'd0, werr, tmo, busy, done};
  end

  always_comb begin
    nstate     = state;
    s_ready    = 1'b0;
    m_valid    = 1'b0;
    m_data     = 8'd0;
    core_start = 1'b0;
    case (state)
      IDLE:   nstate = go ? START : (stream_en && s_valid) ? LOAD : IDLE;
      LOAD: begin
        s_ready = 1'b1;
        nstate  = (s_valid && idx == LAST) ? START : LOAD;
      end
      START: begin
        core_start = 1'b1;
        nstate     = WAIT;
      end
      WAIT:   nstate = core_done ? (from_stream ? UNLOAD : IDLE) : tlast ? IDLE : WAIT;
      UNLOAD: begin
        m_valid = 1'b1;
        m_data  = out_reg[8*idx +: 8];
        nstate  = (m_ready && idx == LAST) ? IDLE : UNLOAD;
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      in_reg      <= '0;
      out_reg     <= '0;
      key_reg     <= '0;
      encrypt     <= 1'b0;
      stream_en   <= 1'b0;
      done        <= 1'b0;
      tmo         <= 1'b0;
      werr        <= 1'b0;
      from_stream <= 1'b0;
      idx         <= '0;
      tcnt        <= '0;
      o_wb_ack    <= 1'b0;
      o_wb_data   <= '0;
    end else begin
      state     <= nstate;
      o_wb_ack  <= req;
      o_wb_data <= (req && !i_wb_we) ? rdata : 32'd0;
      if (wr_ok && sel_in) in_reg[32*k +: 32] <= i_wb_data;
      if (state == LOAD && s_valid) in_reg[8*idx +: 8] <= s_data;
      if (wr_ok && sel_key) key_reg[32*k +: 32] <= i_wb_data;
      if (wr_ok && sel_ctrl) begin
        encrypt   <= i_wb_data[1];
        stream_en <= i_wb_data[2];
      end
      if (state == WAIT && core_done) out_reg <= core_result;
      // sticky status: a new event wins over a same-cycle W1C
      done <= (state == WAIT && core_done) || (done && !(wr && sel_sts && i_wb_data[0]));
      tmo  <= (state == WAIT && !core_done && tlast) || (tmo && !(wr && sel_sts && i_wb_data[2]));
      werr <= (wr && busy && (sel_in || sel_key || sel_ctrl)) || (werr && !(wr && sel_sts && i_wb_data[3]));
      if (state == IDLE) from_stream <= 1'b0;
      else if (state == LOAD) from_stream <= 1'b1;
      // idx wraps to 0 after the last byte so UNLOAD starts from byte 0
      if (state == IDLE) idx <= '0;
      else if ((state == LOAD && s_valid) || (state == UNLOAD && m_ready)) idx <= (idx == LAST) ? 8'd0 : idx + 8'd1;
      if (state == START) tcnt <= '0;
      else if (state == WAIT) tcnt <= tcnt + TW'(1);
    end
  end

`ifdef CIPHER_STREAM_IRQ_EN
  logic ie, irq_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ie    <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (wr_ok && sel_ctrl) ie <= i_wb_data[3];
      irq_q <= ie && (done || tmo);
    end
  end
  assign ie_rd = ie;
  assign irq   = irq_q;
`else
  assign ie_rd = 1'b0;
  assign irq   = 1'b0;
`endif
endmodule

// File: tb/tb_cipher_stream_ctrl.sv
// tb_cipher_stream_ctrl: scoreboard bench for cipher_stream_ctrl with an XOR core stub
module tb_cipher_stream_ctrl;
  localparam logic [31:0] B = 32'h3000_0000;
  localparam logic [31:0] A_IN = B, A_OUT = B + 8, A_KEY = B + 16, A_CTRL = B + 24, A_STS = B + 28;
`ifdef CIPHER_STREAM_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic clk = 1'b0, reset_n = 1'b0;
  logic cyc = 0, stb = 0, we = 0;
  logic [31:0] addr = 0, wdata = 0, o_wb_data;
  logic o_wb_ack, o_wb_stall;
  logic s_valid = 0, s_ready, m_valid, m_ready = 1, core_start, core_encrypt, core_done, irq;
  logic [7:0] s_data = 0, m_data;
  logic [63:0] core_text, core_key, core_result;
  logic [2:0] sr;
  logic stub_en = 1'b1;

  always #5 clk = ~clk;

  cipher_stream_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_addr(addr), .i_wb_data(wdata),
    .o_wb_ack(o_wb_ack), .o_wb_stall(o_wb_stall), .o_wb_data(o_wb_data),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .core_text(core_text), .core_key(core_key), .core_start(core_start),
    .core_encrypt(core_encrypt), .core_result(core_result), .core_done(core_done), .irq(irq)
  );

  // core stub: result = text ^ key, done three cycles after the start cycle
  always @(posedge clk or negedge reset_n)
    if (!reset_n) sr <= '0;
    else sr <= {sr[1:0], core_start & stub_en};
  assign core_done   = sr[2];
  assign core_result = core_text ^ core_key;

  int total = 0, bad = 0, starts = 0, hs = 0;
  logic [32:0] wb_q[$];
  logic [7:0] m_q[$];
  logic stall = 1'b0;
  logic [7:0] prev = 8'd0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [32:0] e;
    #1;
    if (core_start) starts++;
    if (o_wb_ack) begin
      if (wb_q.size() == 0) chk("wb_unexpected_ack", {63'd0, o_wb_ack}, 64'd0);
      else begin
        e = wb_q.pop_front();
        if (e[32]) chk("wb_read", {32'd0, o_wb_data}, {32'd0, e[31:0]});
      end
    end
    if (stall && m_valid) chk("m_stable", {56'd0, m_data}, {56'd0, prev});
    if (m_valid && m_ready) begin
      hs++;
      if (m_q.size() == 0) chk("m_extra_byte", {63'd0, m_valid}, 64'd0);
      else chk("m_data", {56'd0, m_data}, {56'd0, m_q.pop_front()});
    end
    stall = m_valid && !m_ready;
    prev  = m_data;
  end

  task automatic wb_xfer(input logic [31:0] a, input logic [31:0] d, input logic w);
    @(negedge clk);
    cyc = 1; stb = 1; we = w; addr = a; wdata = d;
    @(negedge clk);
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    wb_q.push_back({1'b0, 32'd0});
    wb_xfer(a, d, 1'b1);
  endtask

  task automatic wb_read(input logic [31:0] a, input logic [31:0] exp);
    wb_q.push_back({1'b1, exp});
    wb_xfer(a, 32'd0, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    repeat (gap) @(negedge clk);
    s_valid = 1; s_data = b;
    #1;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n == 50) chk("s_ready_timeout", {63'd0, s_ready}, 64'd1);
    @(negedge clk);
    s_valid = 0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while ((m_q.size() != 0 || wb_q.size() != 0) && n < 300) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("queues_drained", 64'(m_q.size() + wb_q.size()), 64'd0);
  endtask

  task automatic chk_reset_outs();
    chk("reset_outputs", {19'd0, o_wb_ack, o_wb_data, s_ready, m_valid, m_data, core_start, irq}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] kv, iv, ov, sv, bv;
    int base, n;
    kv = 64'h1334_5779_9BBC_DFF1;
    iv = 64'h0123_4567_89AB_CDEF;
    repeat (2) @(negedge clk);
    #1 chk_reset_outs();
    @(negedge clk) reset_n = 1;

    // Wishbone load, GO, read back
    wb_write(A_KEY, kv[31:0]);
    wb_write(A_KEY + 4, kv[63:32]);
    wb_write(A_IN, iv[31:0]);
    wb_write(A_IN + 4, iv[63:32]);
    wb_read(A_KEY, kv[31:0]);
    wb_read(A_IN + 4, iv[63:32]);
    wb_read(A_STS, 32'h0);
    wb_write(A_CTRL, 32'h1);
    repeat (10) @(negedge clk);
    ov = iv ^ kv;
    wb_read(A_OUT, ov[31:0]);
    wb_read(A_OUT + 4, ov[63:32]);
    wb_read(A_STS, 32'h1);
    wb_read(A_CTRL, 32'h0);
    chk("start_pulses", 64'(starts), 64'd1);
    wb_write(A_OUT, 32'hFFFF_FFFF);
    wb_read(A_OUT, ov[31:0]);
    wb_xfer(B + 32, 32'd0, 1'b0);
    #2 chk("unmapped_no_ack", {63'd0, o_wb_ack}, 64'd0);
    wb_write(A_STS, 32'h1);
    wb_read(A_STS, 32'h0);

    // stream path, m_ready held high
    wb_write(A_CTRL, 32'h6);
    wb_read(A_CTRL, 32'h6);
    chk("core_encrypt", {63'd0, core_encrypt}, 64'd1);
    for (int i = 0; i < 8; i++) begin
      sv[8*i +: 8] = 8'(i);
      m_q.push_back(8'(i) ^ kv[8*i +: 8]);
    end
    base = hs;
    for (int i = 0; i < 8; i++) send_byte(sv[8*i +: 8], 0);
    wait_empty();
    chk("stream_handshakes", 64'(hs - base), 64'd8);
    wb_read(A_STS, 32'h1);
    chk("start_pulses_stream", 64'(starts), 64'd2);

    // backpressure: input gaps and a 5-cycle m_ready stall mid-UNLOAD
    wb_write(A_STS, 32'h1);
    for (int i = 0; i < 8; i++) begin
      bv[8*i +: 8] = 8'h30 + 8'(i) * 8'h11;
      m_q.push_back(bv[8*i +: 8] ^ kv[8*i +: 8]);
    end
    base = hs;
    fork
      for (int i = 0; i < 8; i++) send_byte(bv[8*i +: 8], i % 3);
      begin
        n = 0;
        while (hs < base + 3 && n < 500) begin
          @(negedge clk);
          n++;
        end
        m_ready = 0;
        repeat (5) @(negedge clk);
        m_ready = 1;
      end
    join
    wait_empty();
    chk("bp_handshakes", 64'(hs - base), 64'd8);
    ov = bv ^ kv;
    wb_read(A_OUT + 4, ov[63:32]);

    // busy protection: KEY write during WAIT dropped, WERR set then W1C
    wb_write(A_STS, 32'h1);
    wb_write(A_CTRL, 32'h1);
    wb_write(A_KEY, 32'hDEAD_BEEF);
    repeat (10) @(negedge clk);
    wb_read(A_KEY, kv[31:0]);
    wb_read(A_STS, 32'h9);
    wb_write(A_STS, 32'h8);
    wb_read(A_STS, 32'h1);

    // timeout: stub silent
    stub_en = 0;
    wb_write(A_STS, 32'h1);
    wb_write(A_CTRL, 32'h9);
    repeat (60) @(negedge clk);
    wb_read(A_STS, 32'h2);
    repeat (10) @(negedge clk);
    wb_read(A_STS, 32'h4);
    wb_read(A_OUT, ov[31:0]);
    wb_read(A_CTRL, {28'd0, IRQ_ON, 3'd0});
    #2 chk("irq_on_timeout", {63'd0, irq}, {63'd0, IRQ_ON});
    wb_write(A_STS, 32'h4);
    repeat (2) @(negedge clk);
    #1 chk("irq_after_w1c", {63'd0, irq}, 64'd0);
    stub_en = 1;

    // reset mid-LOAD after 3 bytes, then a clean block from index 0
    wb_write(A_CTRL, 32'h4);
    for (int i = 0; i < 3; i++) send_byte(8'hE0 + 8'(i), 0);
    reset_n = 0;
    #1 chk_reset_outs();
    @(negedge clk) reset_n = 1;
    wb_read(A_STS, 32'h0);
    wb_write(A_CTRL, 32'h4);
    for (int i = 0; i < 8; i++) begin
      sv[8*i +: 8] = 8'hC0 + 8'(i);
      m_q.push_back(sv[8*i +: 8]);
    end
    base = hs;
    for (int i = 0; i < 8; i++) send_byte(sv[8*i +: 8], 0);
    wait_empty();
    chk("post_reset_handshakes", 64'(hs - base), 64'd8);
    wb_read(A_IN, sv[31:0]);
    wait_empty();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
